// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Per-frame framing options captured at the pop cycle.
  typedef struct packed {
    logic par_en;
    logic par_odd;
    logic stop2;
  } tx_cfg_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: bit_end_o fires on the last clk of every bit.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_end_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  // Count down to zero then reload; never decrements past zero, so an
  // all-ones divisor cannot wrap.
  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_end_o = run_i && (cnt_q == '0);
    if (load_i) begin
      div_d = div_i;
      cnt_d = div_i;
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? div_q : cnt_q - DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: pops a fall-through FIFO and serialises one
// frame (start, data LSB first, optional parity, 1 or 2 stops) per word.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              tx_en_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic              parity_en_i,
  input  logic              parity_odd_i,
  input  logic              stop2_i,
  input  logic              fifo_valid_i,
  input  logic [DATA_W-1:0] fifo_rdata_i,
  output logic              fifo_ren_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  tx_cfg_t           cfg_q, cfg_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;

  logic pop;
  logic busy;
  logic bit_end;

  assign busy = (state_q != ST_IDLE);
  // Reset gates the pop so nothing leaves the FIFO while the block is held.
  assign pop  = (state_q == ST_IDLE) && tx_en_i && fifo_valid_i && !reset_i;

  assign fifo_ren_o = pop;
  assign tx_o       = tx_q;
  assign busy_o     = busy;
  assign done_o     = done_q;

  uart_baud_tick #(
    .DIV_W(DIV_W)
  ) u_baud_tick (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .load_i   (pop),
    .run_i    (busy),
    .div_i    (baud_div_i),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    par_d   = par_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d       = fifo_rdata_i;
          cfg_d.par_en  = parity_en_i;
          cfg_d.par_odd = parity_odd_i;
          cfg_d.stop2   = stop2_i;
          par_d         = (^fifo_rdata_i) ^ (parity_odd_i == PARITY_ODD);
          idx_d         = '0;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = cfg_q.par_en ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (cfg_q.stop2 && (idx_q == '0)) begin
            idx_d = IDX_W'(1);
          end else begin
            idx_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the state one clk later, so each bit starts on
  // the cycle after its state/index update.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_q;
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      cfg_q   <= cfg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, sets the data bits per frame.
REQ-002 Parameter DIV_W, default 16, sets the baud divisor width.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, asynchronous and active-high.
REQ-005 tx_en_i  input  1  transmitter enable; gates new frame starts only.
REQ-006 baud_div_i  input  DIV_W  bit period minus one, in clk_i cycles.
REQ-007 parity_en_i  input  1  appends a parity bit after the data bits.
REQ-008 parity_odd_i  input  1  1 selects odd parity, 0 selects even.
REQ-009 stop2_i  input  1  1 selects two stop bits, 0 selects one.
REQ-010 fifo_valid_i  input  1  TX FIFO non-empty; fifo_rdata_i is valid in the same cycle (fall-through).
REQ-011 fifo_rdata_i  input  DATA_W  TX FIFO head word.
REQ-012 fifo_ren_o  output  1  single-cycle FIFO pop strobe.
REQ-013 tx_o  output  1  serial line, registered, idle high.
REQ-014 busy_o  output  1  high whenever state is not IDLE.
REQ-015 done_o  output  1  one-cycle pulse marking frame completion.

Function
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 In IDLE, fifo_ren_o SHALL be asserted combinationally iff tx_en_i and fifo_valid_i.
REQ-018 On a pop cycle, fifo_rdata_i, baud_div_i, parity_en_i, parity_odd_i and stop2_i SHALL be latched, and the state SHALL move to START.
REQ-019 Config input changes after the pop cycle SHALL NOT affect the frame in progress.
REQ-020 Each bit SHALL last exactly (latched baud_div + 1) clk_i cycles; baud_div 0 gives 1 cycle per bit.
REQ-021 tx_o SHALL drive 0 for START, then the data bits LSB first for DATA, then PARITY, then 1 for each STOP bit.
REQ-022 tx_o SHALL change on the first cycle of each bit, one cycle after the state or bit-index update.
REQ-023 The parity bit SHALL be the XOR of the data bits when even, and its inverse when odd.
REQ-024 Transitions: START->DATA after 1 bit; DATA->PARITY (parity_en) or DATA->STOP after DATA_W bits; PARITY->STOP after 1 bit; STOP->IDLE after 1 or 2 bits.
REQ-025 done_o SHALL be high for exactly the first IDLE cycle after STOP.
REQ-026 A pop MAY occur in that same cycle, giving back-to-back frames with exactly one extra idle-high clk between frames.
REQ-027 Deasserting tx_en_i mid-frame SHALL let the current frame complete and SHALL block further pops.
REQ-028 fifo_ren_o SHALL never assert outside IDLE or when fifo_valid_i is low, so at most one pop occurs per frame.
REQ-029 The bit-period counter and the bit-index counter SHALL reload on every bit boundary, with no wrap-around glitches at DIV_W all-ones.

Reset
REQ-030 Reset SHALL set state IDLE, tx_o 1, busy_o 0, done_o 0, fifo_ren_o 0, and clear all counters and the shift register.
REQ-031 Reset asserted mid-frame SHALL immediately abort the frame (tx_o to 1), and the aborted word SHALL NOT be retransmitted.

Structure
REQ-032 Package uart_pkg SHALL hold the tx_state_e enum, the DATA_W and DIV_W defaults, and the parity-mode constants.
REQ-033 The bit-period counter SHALL be sub-module uart_baud_tick, which outputs a one-cycle bit_end strobe and is reloaded at frame start.

Verification
REQ-034 baud_div=3, 0xA5, no parity, 1 stop -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 4 clk (40 clk frame), then done_o pulses once.
REQ-035 baud_div=0, parity even, 0x07 -> 11-clk frame with parity bit 1; repeat with odd parity -> parity bit 0.
REQ-036 FIFO holds 0x55 and 0xAA with tx_en=1 -> exactly 2 pops, 1-clk gap between frames, then idle with no further pops.
REQ-037 stop2=1 with baud_div changed mid-frame -> stop lasts 2 bits at the originally latched rate.
REQ-038 reset_i pulsed mid-DATA -> tx_o=1 and busy_o=0 asynchronously, no pop until reset is released.
REQ-039 tx_en=0 with fifo_valid=1 for 100 clk -> fifo_ren_o stays 0 and tx_o stays 1.
